// File: rtl/tx_path_top.sv
// QPSK transmit datapath: maps one (I,Q) bit pair per accepted symbol to +/-AMP
// levels and repeats it for SPS samples on a 24-bit {I, Q} output stream.
module tx_path_top #(
    parameter int SPS       = 4,
    parameter int AMP       = 1447,
    parameter int IN_DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_I,
    input  logic                 in_Q,
    input  logic [IN_DATA_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [23:0]          out_data
);

    localparam logic [11:0] POS_LVL  = 12'(AMP);
    localparam logic [11:0] NEG_LVL  = 12'(-AMP);
    localparam logic [3:0]  LAST_CNT = 4'(SPS - 1);

    logic [3:0]  cnt;
    logic        last_sample;
    logic        accept;
    logic        consume;
    logic [11:0] lvl_i;
    logic [11:0] lvl_q;
    logic        unused_in_data;

    assign unused_in_data = ^in_data;

    assign last_sample = (cnt == LAST_CNT);
    // A new symbol may only enter once the final repeat of the current one leaves
    assign in_ready    = rst && (!out_valid || (out_ready && last_sample));
    assign accept      = in_valid && in_ready;
    assign consume     = out_valid && out_ready;

    assign lvl_i = in_I ? NEG_LVL : POS_LVL;
    assign lvl_q = in_Q ? NEG_LVL : POS_LVL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
        end else if (accept) begin
            out_data  <= {lvl_i, lvl_q};
            out_valid <= 1'b1;
            cnt       <= '0;
        end else if (consume) begin
            if (last_sample) begin
                out_valid <= 1'b0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tx_path_top.sv
// Randomized self-checking bench for tx_path_top against a queue-based sample model.
module tb_tx_path_top;

    localparam int SPS = 4;
    localparam int AMP = 1447;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_I = 1'b0;
    logic        in_Q = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_data;

    // Model: every accepted symbol becomes SPS queued output samples
    logic [23:0] exp_q[$];
    logic [1:0]  pend[$];
    logic [23:0] capture[$];
    logic [23:0] last_data = '0;
    bit          cap_on = 0;
    int          check_count = 0;
    int          fail_count = 0;

    tx_path_top #(.SPS(SPS), .AMP(AMP), .IN_DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_I(in_I), .in_Q(in_Q), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] map_bit(logic b);
        int v;
        v = b ? -AMP : AMP;
        return v[11:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge
    task automatic applyStimulus(input bit valid_en, input bit ready_val);
        bit          exp_valid, exp_ready, acc, cons;
        logic [23:0] sym;
        in_valid = valid_en && (pend.size() > 0);
        if (in_valid) {in_I, in_Q} = pend[0];
        else          {in_I, in_Q} = 2'($urandom);
        in_data   = 8'($urandom);
        out_ready = ready_val;
        exp_valid = exp_q.size() > 0;
        exp_ready = rst && (!exp_valid || (exp_q.size() == 1 && ready_val));
        @(negedge clk);
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        checkOutput("out_data", {8'd0, out_data}, {8'd0, exp_valid ? exp_q[0] : last_data});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        if (cap_on && out_valid) capture.push_back(out_data);
        @(posedge clk);
        acc  = in_valid && exp_ready;
        cons = exp_valid && ready_val && rst;
        if (cons) void'(exp_q.pop_front());
        if (acc) begin
            sym = {map_bit(in_I), map_bit(in_Q)};
            repeat (SPS) exp_q.push_back(sym);
            last_data = sym;
            void'(pend.pop_front());
        end
        #1;
    endtask

    task automatic run_until_idle(input bit random_mode, input int budget);
        int n;
        n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < budget) begin
            if (random_mode) applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            else             applyStimulus(1'b1, 1'b1);
            n++;
        end
        checkOutput("idle_timeout", {31'd0, (pend.size() > 0 || exp_q.size() > 0)}, 32'd0);
        applyStimulus(1'b0, 1'b1);
    endtask

    initial begin
        logic [23:0] lit_tab [4];
        bit triggered;
        int hold_left;
        int n;
        lit_tab[0] = 24'h5A75A7;
        lit_tab[1] = 24'h5A7A59;
        lit_tab[2] = 24'hA595A7;
        lit_tab[3] = 24'hA59A59;

        // Reset held with in_valid high: nothing accepted
        pend.push_back(2'b00); pend.push_back(2'b01);
        pend.push_back(2'b10); pend.push_back(2'b11);
        #1;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        rst = 1'b1;

        // Mapping of all four bit pairs
        cap_on = 1;
        run_until_idle(1'b0, 40);
        cap_on = 0;
        checkOutput("map_count", capture.size(), 32'd16);
        if (capture.size() == 16) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("map_first%0d", k), {8'd0, capture[4*k]}, {8'd0, lit_tab[k]});
                checkOutput($sformatf("map_last%0d", k), {8'd0, capture[4*k+3]}, {8'd0, lit_tab[k]});
            end
        end

        // Streaming of 100 random symbols
        for (int k = 0; k < 100; k++) pend.push_back(2'($urandom));
        run_until_idle(1'b0, 500);

        // Backpressure for 3 cycles at cnt==2
        pend.push_back(2'($urandom)); pend.push_back(2'($urandom));
        triggered = 0; hold_left = 0; n = 0;
        while ((pend.size() > 0 || exp_q.size() > 0) && n < 40) begin
            if (!triggered && exp_q.size() == SPS - 2) begin
                triggered = 1;
                hold_left = 3;
            end
            applyStimulus(1'b1, hold_left == 0);
            if (hold_left > 0) hold_left--;
            n++;
        end
        checkOutput("bp_triggered", {31'd0, triggered}, 32'd1);
        checkOutput("bp_timeout", {31'd0, (pend.size() > 0 || exp_q.size() > 0)}, 32'd0);
        applyStimulus(1'b0, 1'b1);

        // Random valid/ready traffic
        for (int k = 0; k < 60; k++) pend.push_back(2'($urandom));
        run_until_idle(1'b1, 2000);

        // Reset asserted mid-symbol at cnt==1
        pend.push_back(2'($urandom));
        n = 0;
        while (exp_q.size() != SPS - 1 && n < 10) begin
            applyStimulus(1'b1, 1'b1);
            n++;
        end
        checkOutput("mid_reach", exp_q.size(), SPS - 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_data", {8'd0, out_data}, 32'd0);
        checkOutput("rst_ready", {31'd0, in_ready}, 32'd0);
        exp_q.delete();
        last_data = '0;
        pend.push_back(2'($urandom));
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        rst = 1'b1;
        run_until_idle(1'b0, 20);

        $display("test done: total=%0d bad=%0d", check_count, fail_count);
        $finish;
    end

endmodule
